frame_scheduler: RTL and testbench

FRAME_SCHEDULER -- requirements
Module: frame_scheduler

---
 rtl/frame_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_frame_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_scheduler.sv
`default_nettype none
// ============================================================================
// frame_scheduler : captures toggle-flagged 128-bit TPIU frames from the trace
//   domain into a FIFO and streams them out as 16-bit words (LSB word first).
//   Optional header word per frame: define FRAME_SCHEDULER_HDR_EN.
// Revision: 1.0
// ============================================================================
module frame_scheduler #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         PkAvail,
  input  logic [127:0] Packet,
  input  logic         enable,
  output logic [15:0]  dataOut,
  output logic         dataValid,
  input  logic         dataReady,
  output logic         frameStart,
  output logic         lostFrame,
  output logic [7:0]   dropCount
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] c_DEPTH = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] c_ONE   = (PTR_W+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef FRAME_SCHEDULER_HDR_EN
    S_HDR  = 2'd1,
`endif
    S_WORD = 2'd2
  } state_t;

  logic           r_pkSync1, r_pkSync2, r_pkSync3;
  logic [127:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W:0] r_wrPtr, r_rdPtr;
  logic           r_lostFrame;
  logic [7:0]     r_dropCount;
  state_t         r_state;
  logic [2:0]     r_idx;
  logic           r_dataValid;
  logic           r_frameStart;
  logic [15:0]    r_dataOut;
`ifdef FRAME_SCHEDULER_HDR_EN
  logic [7:0]     r_seq;
`endif

  logic [PTR_W:0]   w_count;
  logic [PTR_W-1:0] w_rdNextIdx;
  logic [127:0]     w_head;
  logic [2:0]       w_idxInc;
  logic             w_toggle, w_full, w_accept, w_pop, w_push, w_drop, w_nextAvail;

  assign w_toggle    = r_pkSync2 ^ r_pkSync3;
  assign w_count     = r_wrPtr - r_rdPtr;
  assign w_full      = (w_count == c_DEPTH);
  assign w_accept    = r_dataValid & dataReady;
  assign w_pop       = w_accept && (r_state == S_WORD) && (r_idx == 3'd7);
  // A pop in the same cycle frees the slot the incoming frame needs.
  assign w_push      = w_toggle && enable && (!w_full || w_pop);
  assign w_drop      = w_toggle && enable && w_full && !w_pop;
  assign w_rdNextIdx = r_rdPtr[PTR_W-1:0] + PTR_W'(1);
  assign w_head      = r_mem[r_rdPtr[PTR_W-1:0]];
  assign w_idxInc    = r_idx + 3'd1;
  assign w_nextAvail = (w_count > c_ONE) || w_push;

`ifndef FRAME_SCHEDULER_HDR_EN
  logic [127:0] w_nextHead;
  // With only the popping frame stored, the next head is the frame arriving now.
  assign w_nextHead = (w_count > c_ONE) ? r_mem[w_rdNextIdx] : Packet;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pkSync1 <= 1'b0;
      r_pkSync2 <= 1'b0;
      r_pkSync3 <= 1'b0;
    end else begin
      r_pkSync1 <= PkAvail;
      r_pkSync2 <= r_pkSync1;
      r_pkSync3 <= r_pkSync2;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr[PTR_W-1:0]] <= Packet;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_lostFrame <= 1'b0;
      r_dropCount <= 8'd0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + c_ONE;
      if (w_pop)  r_rdPtr <= r_rdPtr + c_ONE;
      r_lostFrame <= w_drop;
      if (w_drop && (r_dropCount != 8'hFF)) r_dropCount <= r_dropCount + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_idx        <= 3'd0;
      r_dataValid  <= 1'b0;
      r_frameStart <= 1'b0;
      r_dataOut    <= 16'h0000;
`ifdef FRAME_SCHEDULER_HDR_EN
      r_seq        <= 8'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_count != '0) begin
`ifdef FRAME_SCHEDULER_HDR_EN
            r_state   <= S_HDR;
            r_dataOut <= {8'hA5, r_seq};
`else
            r_state   <= S_WORD;
            r_dataOut <= w_head[15:0];
`endif
            r_idx        <= 3'd0;
            r_dataValid  <= 1'b1;
            r_frameStart <= 1'b1;
          end
        end
`ifdef FRAME_SCHEDULER_HDR_EN
        S_HDR: begin
          if (w_accept) begin
            r_seq        <= r_seq + 8'd1;
            r_state      <= S_WORD;
            r_idx        <= 3'd0;
            r_dataOut    <= w_head[15:0];
            r_frameStart <= 1'b0;
          end
        end
`endif
        S_WORD: begin
          if (w_accept) begin
            if (r_idx == 3'd7) begin
              r_idx <= 3'd0;
              if (w_nextAvail) begin
`ifdef FRAME_SCHEDULER_HDR_EN
                r_state   <= S_HDR;
                r_dataOut <= {8'hA5, r_seq};
`else
                r_dataOut <= w_nextHead[15:0];
`endif
                r_frameStart <= 1'b1;
              end else begin
                r_state      <= S_IDLE;
                r_dataValid  <= 1'b0;
                r_frameStart <= 1'b0;
              end
            end else begin
              r_idx        <= w_idxInc;
              r_dataOut    <= w_head[{w_idxInc, 4'b0000} +: 16];
              r_frameStart <= 1'b0;
            end
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_dataValid  <= 1'b0;
          r_frameStart <= 1'b0;
        end
      endcase
    end
  end

  assign dataOut    = r_dataOut;
  assign dataValid  = r_dataValid;
  assign frameStart = r_frameStart;
  assign lostFrame  = r_lostFrame;
  assign dropCount  = r_dropCount;

endmodule
`default_nettype wire

// File: tb/tb_frame_scheduler.sv
`default_nettype none
// ============================================================================
// tb_frame_scheduler : vector table, corner-case sequences and random traffic
//   checked cycle by cycle against a frame-level reference model.
// Revision: 1.0
// ============================================================================
module tb_frame_scheduler;

  localparam int FIFO_DEPTH = 4;
`ifdef FRAME_SCHEDULER_HDR_EN
  localparam int c_HDR = 1;
`else
  localparam int c_HDR = 0;
`endif
  localparam int c_FIRST = -c_HDR;   // word position -1 is the header word
  localparam logic [127:0] c_PKT_INC = 128'h0007_0006_0005_0004_0003_0002_0001_0000;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         PkAvail = 1'b0;
  logic [127:0] Packet = '0;
  logic         enable = 1'b1;
  logic         dataReady = 1'b1;
  logic [15:0]  dataOut;
  logic         dataValid;
  logic         frameStart;
  logic         lostFrame;
  logic [7:0]   dropCount;

  frame_scheduler #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .PkAvail   (PkAvail),
    .Packet    (Packet),
    .enable    (enable),
    .dataOut   (dataOut),
    .dataValid (dataValid),
    .dataReady (dataReady),
    .frameStart(frameStart),
    .lostFrame (lostFrame),
    .dropCount (dropCount)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFail = 0;

  // Reference model: frames held as whole packets, output position within head.
  logic [127:0] fq[$];
  bit           mValid;
  int           mPos;
  logic [7:0]   mDrop;
  bit           mLost;
  logic [7:0]   mSeq;
  bit           pipeA, pipeB;
  logic [127:0] pipeAPkt, pipeBPkt;

  bit           drvEn = 1'b1;
  bit           drvRdy = 1'b1;
  logic [15:0]  got[$];
  int           lostSeen = 0;

  typedef struct {
    logic [127:0] pkt;
    bit           en;
    int           stallWord;
    int           stallLen;
    int           expCount;
    logic [15:0]  expFirst;
    logic [15:0]  expLast;
  } vec_t;

  vec_t vec[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] expWord();
    logic [127:0] h;
    if (mPos < 0) return {8'hA5, mSeq};
    h = fq[0];
    return h[mPos*16 +: 16];
  endfunction

  task automatic modelClear();
    fq.delete();
    mValid = 1'b0;
    mPos   = c_FIRST;
    mDrop  = 8'd0;
    mLost  = 1'b0;
    mSeq   = 8'd0;
    pipeA  = 1'b0;
    pipeB  = 1'b0;
  endtask

  // One clock: drive inputs at the falling edge, check outputs, advance the model.
  task automatic step(input bit tog, input logic [127:0] pkt);
    bit acc, pop, canPush, push, drop;
    int sizeBefore;
    logic [127:0] dummy;
    @(negedge clk);
    enable    = drvEn;
    dataReady = drvRdy;
    if (tog) begin
      PkAvail = ~PkAvail;
      Packet  = pkt;
    end
    #1;
    chk("dataValid", {31'd0, dataValid}, {31'd0, mValid});
    if (mValid) begin
      chk("dataOut", {16'd0, dataOut}, {16'd0, expWord()});
      chk("frameStart", {31'd0, frameStart}, {31'd0, (mPos == c_FIRST)});
    end
    chk("lostFrame", {31'd0, lostFrame}, {31'd0, mLost});
    chk("dropCount", {24'd0, dropCount}, {24'd0, mDrop});
    if (lostFrame) lostSeen++;
    if (dataValid && dataReady) got.push_back(dataOut);

    acc        = mValid && dataReady;
    pop        = acc && (mPos == 7);
    canPush    = (fq.size() < FIFO_DEPTH) || pop;
    push       = pipeB && enable && canPush;
    drop       = pipeB && enable && !canPush;
    sizeBefore = fq.size();
    if (acc) begin
      if (mPos == 7) dummy = fq.pop_front();
      else begin
        if (mPos < 0) mSeq++;
        mPos++;
      end
    end
    if (push) fq.push_back(pipeBPkt);
    if (pop) begin
      mValid = (fq.size() > 0);
      mPos   = c_FIRST;
    end else if (!mValid && sizeBefore > 0) begin
      mValid = 1'b1;
      mPos   = c_FIRST;
    end
    mLost = drop;
    if (drop && mDrop != 8'hFF) mDrop++;
    pipeB    = pipeA;
    pipeBPkt = pipeAPkt;
    pipeA    = tog;
    pipeAPkt = pkt;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, Packet);
  endtask

  task automatic doReset(input string tag);
    rstn    = 1'b0;
    PkAvail = 1'b0;
    #1;
    chk({tag, " dataValid"}, {31'd0, dataValid}, 32'd0);
    chk({tag, " frameStart"}, {31'd0, frameStart}, 32'd0);
    chk({tag, " lostFrame"}, {31'd0, lostFrame}, 32'd0);
    chk({tag, " dataOut"}, {16'd0, dataOut}, 32'd0);
    chk({tag, " dropCount"}, {24'd0, dropCount}, 32'd0);
    modelClear();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int n;
    int stallLeft;
    int expN;
    int gap;
    logic [15:0] w;

    modelClear();
    repeat (2) @(negedge clk);
    doReset("reset");

    // Table-driven single frames
    vec[0] = '{c_PKT_INC, 1'b1, 0, 0, 8, 16'h0000, 16'h0007};
    vec[1] = '{c_PKT_INC, 1'b1, 3, 5, 8, 16'h0000, 16'h0007};
    vec[2] = '{128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0, 0, 0, 0, 16'h0000, 16'h0000};
    vec[3] = '{128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF, 1'b1, 0, 2, 8, 16'hCDEF, 16'hDEAD};
    vec[4] = '{128'hA0A1_B2B3_C4C5_D6D7_E8E9_FAFB_0C0D_1E1F, 1'b1, 7, 3, 8, 16'h1E1F, 16'hA0A1};
    for (int i = 0; i < 5; i++) begin
      stallLeft = vec[i].stallLen;
      got.delete();
      drvEn  = vec[i].en;
      drvRdy = 1'b1;
      step(1'b1, vec[i].pkt);
      for (int k = 0; k < 30; k++) begin
        if (mValid && stallLeft > 0 && got.size() == vec[i].stallWord + c_HDR) begin
          drvRdy = 1'b0;
          stallLeft--;
        end else drvRdy = 1'b1;
        step(1'b0, vec[i].pkt);
      end
      expN = (vec[i].expCount > 0) ? vec[i].expCount + c_HDR : 0;
      chk($sformatf("vec%0d words", i), got.size(), expN);
      if (vec[i].expCount > 0 && got.size() == expN) begin
        w = got[c_HDR];
        chk($sformatf("vec%0d first", i), {16'd0, w}, {16'd0, vec[i].expFirst});
        w = got[expN-1];
        chk($sformatf("vec%0d last", i), {16'd0, w}, {16'd0, vec[i].expLast});
      end
    end
    drvEn = 1'b1;

    // First valid latency after the PkAvail edge
    drvRdy = 1'b1;
    step(1'b1, c_PKT_INC);
    for (n = 1; n <= 20; n++) begin
      step(1'b0, Packet);
      if (dataValid) break;
    end
    chk("first valid latency", n, 4);
    idle(20);

    // Overflow and saturation with the sink stalled
    drvRdy = 1'b0;
    lostSeen = 0;
    for (int t = 0; t < 6; t++) begin
      step(1'b1, {$urandom, $urandom, $urandom, $urandom});
      idle(2);
    end
    idle(4);
    chk("ovf dropCount", {24'd0, dropCount}, 32'd2);
    chk("ovf lostPulses", lostSeen, 2);
    chk("ovf valid held", {31'd0, dataValid}, 32'd1);
    for (int t = 0; t < 300; t++) begin
      step(1'b1, {$urandom, $urandom, $urandom, $urandom});
      idle(2);
    end
    idle(4);
    chk("ovf saturate", {24'd0, dropCount}, 32'd255);
    got.delete();
    drvRdy = 1'b1;
    idle(60);
    chk("ovf drained words", got.size(), 4 * (8 + c_HDR));

    // Enable dropped mid-frame does not truncate it
    got.delete();
    drvEn = 1'b1;
    step(1'b1, 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100);
    for (int k = 0; k < 30; k++) begin
      if (got.size() == 4 + c_HDR) drvEn = 1'b0;
      step(1'b0, Packet);
    end
    chk("enable-drop frame words", got.size(), 8 + c_HDR);
    drvEn = 1'b1;
    idle(4);

    // Reset at word 5 with two frames queued behind it
    doReset("reset pre-run");
    got.delete();
    step(1'b1, 128'h1117_1116_1115_1114_1113_1112_1111_1110);
    idle(2);
    step(1'b1, 128'h2227_2226_2225_2224_2223_2222_2221_2220);
    idle(2);
    step(1'b1, 128'h3337_3336_3335_3334_3333_3332_3331_3330);
    for (int k = 0; k < 20 && got.size() != 5 + c_HDR; k++) step(1'b0, Packet);
    chk("reached word 5", got.size(), 5 + c_HDR);
    doReset("reset mid-frame");
    got.delete();
    idle(25);
    chk("no words after reset", got.size(), 0);
    step(1'b1, 128'h4447_4446_4445_4444_4443_4442_4441_4440);
    idle(20);
    chk("post-reset frame words", got.size(), 8 + c_HDR);

    // Random traffic against the model
    gap = 3;
    for (int k = 0; k < 3000; k++) begin
      drvRdy = ($urandom_range(0, 9) < 7);
      drvEn  = ($urandom_range(0, 19) != 0);
      if (k % 1000 == 999) begin
        doReset("reset random");
        gap = 3;
      end
      if (gap >= 3 && $urandom_range(0, 2) == 0) begin
        step(1'b1, {$urandom, $urandom, $urandom, $urandom});
        gap = 1;
      end else begin
        step(1'b0, Packet);
        gap++;
      end
    end
    drvRdy = 1'b1;
    drvEn  = 1'b1;
    idle(60);
    chk("final drained valid", {31'd0, dataValid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
`default_nettype wire
